// File: rtl/burst_seq_pkg.sv
// Shared types and constants for the radar burst sequencer.
`timescale 1ns/1ps
package burst_seq_pkg;

  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned DEF_PER_W  = 16;
  localparam int unsigned DEF_BEAM_W = 4;
  localparam int unsigned BURST_W    = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/seq_window_cmp.sv
// Registered "count inside [start, start+len)" flag, used for both TX gate and RX window.
`timescale 1ns/1ps
module seq_window_cmp #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_hit
);

  localparam int unsigned W = (CNT_W > LEN_W) ? CNT_W : LEN_W;

  logic [W-1:0] w_offset;
  logic         w_hit;
  logic         r_hit;

  // Offset form avoids overflow of start+len near the top of the count range.
  always_comb begin
    w_offset = W'(i_cnt) - W'(i_start);
    w_hit    = i_en && (i_cnt >= i_start) && (w_offset < W'(i_len));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= w_hit;
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/burst_sequencer.sv
// PRI / beam sequencer: TX gate, RX window, beam index and frame pulse.
// Optional BURST_SEQ_STAGGER_EN adds Prf_stagger for dual-PRF on odd PRIs.
`timescale 1ns/1ps
module burst_sequencer
  import burst_seq_pkg::*;
#(
  parameter int unsigned PER_W  = DEF_PER_W,
  parameter int unsigned BEAM_W = DEF_BEAM_W
) (
  input  logic               Clk_in,
  input  logic               Rst_n,
  input  logic               Enable,
  input  logic [PER_W-1:0]   Prf_period,
`ifdef BURST_SEQ_STAGGER_EN
  input  logic [PER_W-1:0]   Prf_stagger,
`endif
  input  logic [BURST_W-1:0] Burst_len,
  input  logic [PER_W-1:0]   Rx_delay,
  input  logic [PER_W-1:0]   Rx_len,
  input  logic [BEAM_W-1:0]  Num_beams,
  output logic               gate,
  output logic               Rx_window,
  output logic [BEAM_W-1:0]  Beam_idx,
  output logic               Frame_done,
  output logic               Busy
);

  seq_state_t r_state, w_state_nxt;

  logic [PER_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [BEAM_W-1:0]  r_beam,      w_beam_nxt;
  logic [PER_W-1:0]   r_period,    w_period_nxt;
  logic [BURST_W-1:0] r_burst,     w_burst_nxt;
  logic [PER_W-1:0]   r_rx_delay,  w_rx_delay_nxt;
  logic [PER_W-1:0]   r_rx_len,    w_rx_len_nxt;
  logic [BEAM_W-1:0]  r_num_beams, w_num_beams_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic               r_busy,      w_busy_nxt;

  logic               w_last_cnt;
  logic               w_last_beam;
  logic               w_pri_start;
  logic [BEAM_W-1:0]  w_pri_beam;
  logic [PER_W-1:0]   w_per_raw;
  logic [PER_W-1:0]   w_per_eff;
  logic               w_run_nxt;

  // Beam index the next PRI would carry; drives the stagger parity.
  always_comb begin
    w_last_cnt  = (r_cnt == r_period - PER_W'(1));
    w_last_beam = (r_beam == r_num_beams);
    w_pri_beam  = (r_state == S_RUN && !w_last_beam) ? r_beam + BEAM_W'(1) : '0;
  end

`ifdef BURST_SEQ_STAGGER_EN
  logic [PER_W:0]   w_stag_sum;
  logic [PER_W-1:0] w_per_stag;

  always_comb begin
    w_stag_sum = {1'b0, Prf_period} + {1'b0, Prf_stagger};
    w_per_stag = w_stag_sum[PER_W] ? '1 : w_stag_sum[PER_W-1:0];
    w_per_raw  = w_pri_beam[0] ? w_per_stag : Prf_period;
  end
`else
  assign w_per_raw = Prf_period;
`endif

  assign w_per_eff = (w_per_raw < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : w_per_raw;

  // Next-state and register-input logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_beam_nxt       = r_beam;
    w_period_nxt     = r_period;
    w_burst_nxt      = r_burst;
    w_rx_delay_nxt   = r_rx_delay;
    w_rx_len_nxt     = r_rx_len;
    w_num_beams_nxt  = r_num_beams;
    w_frame_done_nxt = 1'b0;
    w_busy_nxt       = r_busy;
    w_pri_start      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Enable) begin
          w_state_nxt     = S_RUN;
          w_cnt_nxt       = '0;
          w_beam_nxt      = '0;
          w_busy_nxt      = 1'b1;
          w_pri_start     = 1'b1;
          w_num_beams_nxt = Num_beams;
        end
      end
      S_RUN: begin
        if (w_last_cnt) begin
          w_cnt_nxt        = '0;
          w_frame_done_nxt = w_last_beam;
          if (Enable) begin
            w_beam_nxt  = w_pri_beam;
            w_pri_start = 1'b1;
            if (w_last_beam) begin
              w_num_beams_nxt = Num_beams;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_beam_nxt  = '0;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + PER_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (w_pri_start) begin
      w_period_nxt   = w_per_eff;
      w_burst_nxt    = Burst_len;
      w_rx_delay_nxt = Rx_delay;
      w_rx_len_nxt   = Rx_len;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_beam       <= '0;
      r_period     <= PER_W'(MIN_PERIOD);
      r_burst      <= '0;
      r_rx_delay   <= '0;
      r_rx_len     <= '0;
      r_num_beams  <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_beam       <= w_beam_nxt;
      r_period     <= w_period_nxt;
      r_burst      <= w_burst_nxt;
      r_rx_delay   <= w_rx_delay_nxt;
      r_rx_len     <= w_rx_len_nxt;
      r_num_beams  <= w_num_beams_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Window flags are computed from next-cycle count so they line up with r_cnt.
  assign w_run_nxt = (w_state_nxt == S_RUN);

  seq_window_cmp #(
    .CNT_W (PER_W),
    .LEN_W (BURST_W)
  ) u_gate_cmp (
    .clk     (Clk_in),
    .rst_n   (Rst_n),
    .i_en    (w_run_nxt),
    .i_cnt   (w_cnt_nxt),
    .i_start ('0),
    .i_len   (w_burst_nxt),
    .o_hit   (gate)
  );

  seq_window_cmp #(
    .CNT_W (PER_W),
    .LEN_W (PER_W)
  ) u_rx_cmp (
    .clk     (Clk_in),
    .rst_n   (Rst_n),
    .i_en    (w_run_nxt),
    .i_cnt   (w_cnt_nxt),
    .i_start (w_rx_delay_nxt),
    .i_len   (w_rx_len_nxt),
    .o_hit   (Rx_window)
  );

  assign Beam_idx   = r_beam;
  assign Frame_done = r_frame_done;
  assign Busy       = r_busy;

endmodule
